sincos: RTL and testbench
=========================

# sincos

Fixed-point CORDIC rotation-mode unit: takes an angle in radians and returns its sine and cosine. It is the inverse-direction companion of the `atan` vectoring unit and uses the same `trig`/`vld` pulse handshake, so the same bench style drives both. Its output format matches the `atan` angle format (signed Q1.10), so `atan` results can be fed straight back in for round-trip checks.

## Interface
- `ITER`, default 12: CORDIC micro-rotations per result, legal range 8..14.
- `clk`, input, 1 bit: single clock, rising-edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `trig`, input, 1 bit: single-cycle start pulse.
- `para_in`, input, 12 bits: angle, signed Q1.10 radians. Legal range is ±1608 (±π/2).
- `vld`, output, 1 bit: single-cycle pulse meaning `sin_y`/`cos_x` are updated.
- `busy`, output, 1 bit: high from the cycle after an accepted `trig` until `vld`, inclusive.
- `sin_y`, output, 12 bits: sine, signed Q1.10.
- `cos_x`, output, 12 bits: cosine, signed Q1.10.

## Operation
- **Reset values:** `vld`=0, `busy`=0, `sin_y`=0, `cos_x`=0. Internal state is IDLE and the iteration counter is 0.
- **FSM states and transitions:**
  - IDLE: waits for `trig`, then goes to ROT.
  - ROT: runs `ITER` cycles, then goes to DONE.
  - DONE: lasts 1 cycle, then goes to IDLE.
- **Capture.** In IDLE with `trig`=1:
  - Clamp `para_in` to [-1608, +1608].
  - z = clamped value << 3 (signed 16-bit, Q2.13).
  - x = K0 = 9949 (0.607253·2^14).
  - y = 0.
  - x and y are signed 16-bit, Q1.14.
- **ROT iteration i (0..ITER-1):**
  - d = sign of z (z ≥ 0 counts as +1).
  - x ← x − d·(y>>>i)
  - y ← y + d·(x>>>i)
  - z ← z − d·ATAN[i]
  - Shifts are arithmetic. All updates use the pre-iteration values.
- **DONE:**
  - `sin_y` = y converted Q1.14 → Q1.10; `cos_x` = x converted the same way.
  - Each result is saturated to [-1024, +1024].
  - `vld` is 1 for this cycle only.
- **Holding:** outputs hold their value until the next DONE.
- **`trig` while busy:** `trig` in ROT or DONE is ignored. No queueing and no restart.
- **Angle 0:** must yield exactly `cos_x` ≈ 1024, `sin_y` ≈ 0. The z=0 rule (d=+1) must not produce a sign flip beyond ±2 LSB.
- **Reset mid-operation:** returns everything to reset values immediately. No `vld` is emitted for the aborted operation.
- **Accuracy:** |error| ≤ 3 LSB (Q1.10) over the full legal range with ITER=12 and rounding enabled.

## Timing
- `trig` sampled high at edge T (state IDLE): the state becomes ROT after T.
- Iterations run on edges T+1 … T+ITER.
- DONE occupies the cycle after edge T+ITER. `vld`=1 and the new outputs are visible after edge T+ITER+1.
- Latency from `trig` to `vld` is ITER+1 cycles (13 at default). Throughput is one result per ITER+2 cycles.
- The earliest next accepted `trig` is at edge T+ITER+2.
- `busy` is registered: it rises after edge T and falls after the edge that clears `vld`.

## Configuration
- `SINCOS_ROUND_EN` defined: the Q1.14 → Q1.10 conversion rounds half-up (add 8, then >>>4) before saturation.
- `SINCOS_ROUND_EN` undefined: the conversion truncates (>>>4 only). The accuracy bound relaxes to ≤ 4 LSB.
- Latency and handshake are identical in both builds.

## Structure
- Package `sincos_pkg` holds:
  - width constants (IN_W=12, DP_W=16, OUT_W=12)
  - K0=9949
  - CLAMP=1608
  - ATAN table, Q?.13: round(atan(2^-i)·2^13) = 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1
  - FSM state enum {IDLE, ROT, DONE}
- One combinational sub-module `sincos_stage`:
  - inputs x, y, z, shift index, ATAN entry
  - outputs next x, y, z
  - instantiated once and time-multiplexed by the counter
- Top level holds the FSM, counter, datapath registers and output conversion.

## Test plan
- `para_in`=0 → after 13 cycles, `vld` pulse with `sin_y`=0, `cos_x`=1024 (±2).
- `para_in`=536 (π/6) → `sin_y`=512, `cos_x`=887 (±3). `para_in`=-804 → `sin_y`=-724, `cos_x`=724 (±3).
- `para_in`=1608 → `sin_y`=1024, `cos_x`=0 (±3). `para_in`=2000 → identical to 1608 (clamp). `para_in`=-2000 → `sin_y`=-1024.
- Sweep -1608..1608 in steps of 1, comparing against `$sin`/`$cos`·1024 → max |err| ≤ 3 LSB. Check `vld` exactly ITER+1 cycles after each `trig`.
- `trig` re-pulsed 5 cycles after a start with a different angle → ignored: one `vld`, result for the first angle. `busy` is high throughout.
- `rst_n` low at cycle 6 of an operation → outputs 0, no `vld`. After release, a fresh `trig` completes normally.

Source files
------------

// File: rtl/sincos_pkg.sv
// sincos_pkg: shared widths, CORDIC constants, arctangent table and FSM encoding
// for the sincos rotation-mode unit.
package sincos_pkg;

  localparam int IN_W  = 12;
  localparam int DP_W  = 16;
  localparam int OUT_W = 12;

  localparam logic signed [DP_W-1:0] K0    = 16'sd9949;
  localparam logic signed [IN_W-1:0] CLAMP = 12'sd1608;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  // round(atan(2^-i) * 2^13), same Q2.13 scaling as the angle register z
  function automatic logic signed [DP_W-1:0] atan_lut(input logic [3:0] i);
    logic signed [DP_W-1:0] a;
    case (i)
      4'd0:    a = 16'sd6434;
      4'd1:    a = 16'sd3798;
      4'd2:    a = 16'sd2007;
      4'd3:    a = 16'sd1019;
      4'd4:    a = 16'sd511;
      4'd5:    a = 16'sd256;
      4'd6:    a = 16'sd128;
      4'd7:    a = 16'sd64;
      4'd8:    a = 16'sd32;
      4'd9:    a = 16'sd16;
      4'd10:   a = 16'sd8;
      4'd11:   a = 16'sd4;
      4'd12:   a = 16'sd2;
      4'd13:   a = 16'sd1;
      default: a = 16'sd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sincos_stage.sv
// sincos_stage: one combinational CORDIC micro-rotation, shared across all
// iterations by the top-level counter.
module sincos_stage
  import sincos_pkg::*;
(
  input  logic signed [DP_W-1:0] x,
  input  logic signed [DP_W-1:0] y,
  input  logic signed [DP_W-1:0] z,
  input  logic [3:0]             shift,
  input  logic signed [DP_W-1:0] atan,
  output logic signed [DP_W-1:0] x_nx,
  output logic signed [DP_W-1:0] y_nx,
  output logic signed [DP_W-1:0] z_nx
);

  logic signed [DP_W-1:0] xs;
  logic signed [DP_W-1:0] ys;

  assign xs = x >>> shift;
  assign ys = y >>> shift;

  // z == 0 rotates positively so an exact-zero angle never flips direction early
  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    if (!z[DP_W-1]) begin
      x_nx = x - ys;
      y_nx = y + xs;
      z_nx = z - atan;
    end else begin
      x_nx = x + ys;
      y_nx = y - xs;
      z_nx = z + atan;
    end
  end

endmodule

// File: rtl/sincos.sv
// sincos: iterative CORDIC rotation-mode sine/cosine with trig/vld handshake.
// Define SINCOS_ROUND_EN to round half-up (instead of truncate) on the Q1.14 -> Q1.10 output.
module sincos
  import sincos_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [11:0] para_in,
  output logic        vld,
  output logic        busy,
  output logic [11:0] sin_y,
  output logic [11:0] cos_x
);

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic signed [DP_W-1:0] x;
  logic signed [DP_W-1:0] y;
  logic signed [DP_W-1:0] z;
  logic signed [DP_W-1:0] x_nx;
  logic signed [DP_W-1:0] y_nx;
  logic signed [DP_W-1:0] z_nx;
  logic signed [IN_W-1:0] ang_in;
  logic signed [IN_W-1:0] ang_c;

  assign ang_in = $signed(para_in);

  always_comb begin
    ang_c = ang_in;
    if (ang_in > CLAMP)
      ang_c = CLAMP;
    else if (ang_in < -CLAMP)
      ang_c = -CLAMP;
  end

  function automatic logic signed [OUT_W-1:0] to_q10(input logic signed [DP_W-1:0] v);
    logic signed [DP_W:0]    t;
    logic signed [OUT_W-1:0] r;
    t = {v[DP_W-1], v};
`ifdef SINCOS_ROUND_EN
    t = t + 17'sd8;
`else
`endif
    t = t >>> 4;
    if (t > 17'sd1024)
      r = 12'sd1024;
    else if (t < -17'sd1024)
      r = -12'sd1024;
    else
      r = t[OUT_W-1:0];
    return r;
  endfunction

  sincos_stage u_stage (
    .x     (x),
    .y     (y),
    .z     (z),
    .shift (cnt),
    .atan  (atan_lut(cnt)),
    .x_nx  (x_nx),
    .y_nx  (y_nx),
    .z_nx  (z_nx)
  );

  // busy holds through DONE so it drops on the same edge that clears vld
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      vld   <= 1'b0;
      busy  <= 1'b0;
      sin_y <= '0;
      cos_x <= '0;
    end else begin
      vld <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            x     <= K0;
            y     <= '0;
            z     <= {{(DP_W-IN_W){ang_c[IN_W-1]}}, ang_c} << 3;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ROT;
          end else begin
            busy <= 1'b0;
          end
        end
        ROT: begin
          x   <= x_nx;
          y   <= y_nx;
          z   <= z_nx;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          sin_y <= to_q10(y);
          cos_x <= to_q10(x);
          vld   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos.sv
// tb_sincos: scoreboard bench for sincos; expected sine/cosine come from $sin/$cos
// of the clamped angle, queued at trig and checked when vld arrives.
module tb_sincos;

  localparam int ITER  = 12;
  localparam int CLAMP = 1608;
`ifdef SINCOS_ROUND_EN
  localparam int TOL = 3;
`else
  localparam int TOL = 4;
`endif

  typedef struct {
    int angle;
    int sin_exp;
    int cos_exp;
    int tol;
  } exp_t;

  exp_t sb[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [11:0] para_in = '0;
  logic        vld;
  logic        busy;
  logic [11:0] sin_y;
  logic [11:0] cos_x;

  int tests = 0;
  int fails = 0;
  int vld_count = 0;

  sincos #(.ITER(ITER)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig    (trig),
    .para_in (para_in),
    .vld     (vld),
    .busy    (busy),
    .sin_y   (sin_y),
    .cos_x   (cos_x)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vld === 1'b1) vld_count++;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int clampAng(input int a);
    return (a > CLAMP) ? CLAMP : (a < -CLAMP) ? -CLAMP : a;
  endfunction

  function automatic int roundReal(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic checkExact(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic checkNear(input string tag, input int obs, input int exp_v, input int tol);
    bit in_tol;
    in_tol = ((obs - exp_v) <= tol) && ((exp_v - obs) <= tol);
    tests++;
    assert (in_tol === 1'b1) else begin
      fails++;
      $error("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp_v, tol);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    int   s;
    int   c;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL scoreboard: got vld with empty queue, want queued entry");
      return;
    end
    e = sb.pop_front();
    s = $signed(sin_y);
    c = $signed(cos_x);
    checkNear($sformatf("sin(%0d)", e.angle), s, e.sin_exp, e.tol);
    checkNear($sformatf("cos(%0d)", e.angle), c, e.cos_exp, e.tol);
  endtask

  // repulse_at < 0 means no second trig during the operation
  task automatic applyStimulus(input int angle, input int repulse_at, input int repulse_angle);
    exp_t e;
    int   edges;
    bit   busy_ok;
    real  a;
    a         = real'(clampAng(angle)) / 1024.0;
    e.angle   = angle;
    e.sin_exp = roundReal($sin(a) * 1024.0);
    e.cos_exp = roundReal($cos(a) * 1024.0);
    e.tol     = (angle == 0) ? 2 : TOL;
    sb.push_back(e);
    @(posedge clk); #1;
    trig    = 1'b1;
    para_in = 12'(angle);
    @(posedge clk); #1;
    trig    = 1'b0;
    edges   = 0;
    busy_ok = 1'b1;
    while (edges < ITER + 8) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (edges == repulse_at) begin
        trig    = 1'b1;
        para_in = 12'(repulse_angle);
      end else begin
        trig = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (vld === 1'b1) break;
    end
    trig = 1'b0;
    checkExact($sformatf("latency(%0d)", angle), edges, ITER + 1);
    checkExact($sformatf("busy_during(%0d)", angle), int'(busy_ok), 1);
    checkExact($sformatf("busy_at_vld(%0d)", angle), int'(busy), 1);
    checkOutput();
    @(posedge clk); #1;
    checkExact($sformatf("vld_pulse(%0d)", angle), int'(vld), 0);
    checkExact($sformatf("busy_fall(%0d)", angle), int'(busy), 0);
  endtask

  initial begin
    int vcnt;

    #2;
    checkExact("reset_vld", int'(vld), 0);
    checkExact("reset_busy", int'(busy), 0);
    checkExact("reset_sin", int'(sin_y), 0);
    checkExact("reset_cos", int'(cos_x), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(0, -1, 0);
    applyStimulus(536, -1, 0);
    applyStimulus(-804, -1, 0);
    applyStimulus(1608, -1, 0);
    applyStimulus(2000, -1, 0);
    applyStimulus(-2000, -1, 0);
    applyStimulus(-1608, -1, 0);

    vcnt = vld_count;
    applyStimulus(536, 5, -804);
    repeat (ITER + 4) @(posedge clk);
    #1;
    checkExact("repulse_single_vld", vld_count - vcnt, 1);

    @(posedge clk); #1;
    trig    = 1'b1;
    para_in = 12'(804);
    @(posedge clk); #1;
    trig = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vcnt  = vld_count;
    rst_n = 1'b0;
    #1;
    checkExact("abort_sin", int'(sin_y), 0);
    checkExact("abort_cos", int'(cos_x), 0);
    checkExact("abort_busy", int'(busy), 0);
    checkExact("abort_vld", int'(vld), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (ITER + 4) @(posedge clk);
    #1;
    checkExact("abort_no_vld", vld_count - vcnt, 0);
    checkExact("abort_hold_sin", int'(sin_y), 0);
    applyStimulus(-804, -1, 0);

    for (int ang = -CLAMP; ang <= CLAMP; ang++) begin
      applyStimulus(ang, -1, 0);
    end

    checkExact("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
